// File: rtl/yarp_pkg.sv
// Shared types for the yarp vector unit: matrix-multiply sequencer states
// and the default-geometry operand row.
package yarp_pkg;

   localparam int VMM_ELEM_WIDTH = 32;
   localparam int VMM_VEC_COUNT  = 4;

   typedef enum logic [2:0] {
      VMM_IDLE,
      VMM_LOAD_A,
      VMM_LOAD_B,
      VMM_COMPUTE,
      VMM_DRAIN
   } vmm_state_e;

   typedef logic [VMM_ELEM_WIDTH*VMM_VEC_COUNT-1:0] vmm_row_t;

endpackage

// File: rtl/valu.sv
// Combinational matrix-multiply datapath: C = A x B, elements wrap modulo
// 2^ELEM_WIDTH. Rows are packed with element j at [ELEM_WIDTH*(j+1)-1 -: ELEM_WIDTH].
module valu #(
   parameter int ELEM_WIDTH = 32,
   parameter int VEC_COUNT  = 4
) (
   input  logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0] a_rows,
   input  logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0] b_rows,
   output logic [VEC_COUNT-1:0][ELEM_WIDTH*VEC_COUNT-1:0] c_rows
);

   genvar gi, gj;
   generate
      for (gi = 0; gi < VEC_COUNT; gi++) begin : g_row
         for (gj = 0; gj < VEC_COUNT; gj++) begin : g_col
            logic [ELEM_WIDTH-1:0] acc;

            // Products and sum are kept at ELEM_WIDTH so overflow simply wraps.
            always_comb begin
               acc = '0;
               for (int k = 0; k < VEC_COUNT; k++) begin
                  acc = acc + a_rows[gi][ELEM_WIDTH*(k+1)-1 -: ELEM_WIDTH]
                            * b_rows[k][ELEM_WIDTH*(gj+1)-1 -: ELEM_WIDTH];
               end
            end

            assign c_rows[gi][ELEM_WIDTH*(gj+1)-1 -: ELEM_WIDTH] = acc;
         end
      end
   endgenerate

endmodule

// File: rtl/valu_mm_seq.sv
// Sequencer around valu: streams in A then B rows, registers them, captures
// C in a single compute cycle and streams C out one row per beat.
module valu_mm_seq
   import yarp_pkg::*;
#(
   parameter int ELEM_WIDTH = VMM_ELEM_WIDTH,
   parameter int VEC_COUNT  = VMM_VEC_COUNT,
   parameter int IDX_W      = $clog2(VEC_COUNT)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            abort,
   output logic                            busy,
   output logic                            done,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ELEM_WIDTH*VEC_COUNT-1:0] in_row,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ELEM_WIDTH*VEC_COUNT-1:0] out_row,
   output logic [IDX_W-1:0]                out_idx
);

   localparam int ROW_W = ELEM_WIDTH * VEC_COUNT;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

   vmm_state_e                    state_q, state_d;
   logic [IDX_W-1:0]              cnt_q, cnt_d;
   logic                          done_q, done_d;
   logic [VEC_COUNT-1:0][ROW_W-1:0] a_q, a_d;
   logic [VEC_COUNT-1:0][ROW_W-1:0] b_q, b_d;
   logic [VEC_COUNT-1:0][ROW_W-1:0] c_q, c_d;
   logic [VEC_COUNT-1:0][ROW_W-1:0] valu_c;

   valu #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .VEC_COUNT  (VEC_COUNT)
   ) u_valu (
      .a_rows (a_q),
      .b_rows (b_q),
      .c_rows (valu_c)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;

      // Abort wins over any handshake in the same cycle; operands are kept.
      if (abort && state_q != VMM_IDLE) begin
         state_d = VMM_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            VMM_IDLE: begin
               if (start) begin
                  state_d = VMM_LOAD_A;
                  cnt_d   = '0;
               end
            end
            VMM_LOAD_A: begin
               if (in_valid) begin
                  a_d[cnt_q] = in_row;
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     state_d = VMM_LOAD_B;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            VMM_LOAD_B: begin
               if (in_valid) begin
                  b_d[cnt_q] = in_row;
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     state_d = VMM_COMPUTE;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            VMM_COMPUTE: begin
               c_d     = valu_c;
               cnt_d   = '0;
               state_d = VMM_DRAIN;
            end
            VMM_DRAIN: begin
               if (out_ready) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     state_d = VMM_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_d = VMM_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= VMM_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
      end
   end

   // All handshake outputs decode straight from registered state.
   assign busy      = (state_q != VMM_IDLE);
   assign in_ready  = (state_q == VMM_LOAD_A) || (state_q == VMM_LOAD_B);
   assign out_valid = (state_q == VMM_DRAIN);
   assign done      = done_q;
   assign out_row   = c_q[cnt_q];
   assign out_idx   = cnt_q;

endmodule
